// File: rtl/poly_osc.sv
// poly_osc: bank of CHANNELS square/pulse oscillators that share one phase adder, serviced round-robin (one voice per clock).
// Defining POLY_OSC_DUTY_EN adds the duty_i port and a pulse-width register per voice; without it every voice is a 50% square.
module poly_osc #(
    parameter int CHANNELS = 4,
    parameter int ACC_W    = 24,
    parameter int CLK_HZ   = 10_000_000,
    parameter int DUTY_W   = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          wr_i,
    input  logic [$clog2(CHANNELS)-1:0]   ch_i,
    input  logic [7:0]                    note_i,
    input  logic                          enable_i,
    input  logic                          retrig_i,
`ifdef POLY_OSC_DUTY_EN
    input  logic [DUTY_W-1:0]             duty_i,
`endif
    output logic [CHANNELS-1:0]           wave_o,
    output logic [$clog2(CHANNELS+1)-1:0] mix_o,
    output logic                          tick_o
);
    localparam int CH_W  = $clog2(CHANNELS);
    localparam int MIX_W = $clog2(CHANNELS + 1);
    localparam logic [DUTY_W-1:0] DUTY_HALF = DUTY_W'(1) << (DUTY_W - 1);
    localparam logic [CH_W-1:0]   LAST_IDX  = CH_W'(CHANNELS - 1);

    // f(120+s) in millihertz: the top MIDI octave; every lower octave is a right shift of it.
    function automatic logic [63:0] top_octave_mhz(input int s);
        case (s)
            0:       return 64'd8372018;
            1:       return 64'd8869844;
            2:       return 64'd9397273;
            3:       return 64'd9956063;
            4:       return 64'd10548082;
            5:       return 64'd11175303;
            6:       return 64'd11839822;
            7:       return 64'd12543854;
            8:       return 64'd13289750;
            9:       return 64'd14080000;
            10:      return 64'd14917240;
            default: return 64'd15804266;
        endcase
    endfunction

    function automatic logic [12*ACC_W-1:0] build_rom();
        logic [12*ACC_W-1:0] rom;
        logic [63:0]         num;
        logic [63:0]         den;
        rom = '0;
        den = 64'(CLK_HZ) * 64'd1000;
        for (int s = 0; s < 12; s++) begin
            num = (64'd1 << ACC_W) * top_octave_mhz(s) * 64'(CHANNELS);
            rom[s*ACC_W +: ACC_W] = ACC_W'((num + den / 64'd2) / den);
        end
        return rom;
    endfunction

    localparam logic [12*ACC_W-1:0] BASE_ROM = build_rom();

    logic [CH_W-1:0]     r_idx;
    logic [ACC_W-1:0]    r_phase [CHANNELS];
    logic [ACC_W-1:0]    r_inc   [CHANNELS];
    logic [CHANNELS-1:0] r_en;
    logic [CHANNELS-1:0] r_wave;
    logic [MIX_W-1:0]    r_mix;
    logic                r_tick;
`ifdef POLY_OSC_DUTY_EN
    logic [DUTY_W-1:0]   r_duty  [CHANNELS];
`endif

    logic [6:0]          w_note;
    logic [3:0]          w_oct;
    logic [3:0]          w_semi;
    logic [3:0]          w_shift;
    logic [ACC_W-1:0]    w_base;
    logic [ACC_W-1:0]    w_inc_new;

    always_comb begin
        w_note    = note_i[7] ? 7'd127 : note_i[6:0];
        w_oct     = 4'(w_note / 7'd12);
        w_semi    = 4'(w_note % 7'd12);
        w_shift   = 4'd10 - w_oct;
        w_base    = '0;
        for (int s = 0; s < 12; s++) begin
            if (w_semi == 4'(s)) begin
                w_base = BASE_ROM[s*ACC_W +: ACC_W];
            end
        end
        w_inc_new = w_base >> w_shift;
    end

    logic [ACC_W-1:0]  w_cur_phase;
    logic [ACC_W-1:0]  w_cur_inc;
    logic              w_cur_en;
    logic [DUTY_W-1:0] w_cur_duty;
    logic [ACC_W-1:0]  w_next_phase;
    logic              w_next_wave;

    // Service of the voice in the current slot; the slot always sees the pre-write inc/en/duty.
    always_comb begin
        w_cur_phase = '0;
        w_cur_inc   = '0;
        w_cur_en    = 1'b0;
        w_cur_duty  = DUTY_HALF;
        for (int c = 0; c < CHANNELS; c++) begin
            if (r_idx == CH_W'(c)) begin
                w_cur_phase = r_phase[c];
                w_cur_inc   = r_inc[c];
                w_cur_en    = r_en[c];
`ifdef POLY_OSC_DUTY_EN
                w_cur_duty  = r_duty[c];
`endif
            end
        end
        w_next_phase = w_cur_en ? (w_cur_phase + w_cur_inc) : w_cur_phase;
        if (wr_i && retrig_i && (ch_i == r_idx)) begin
            w_next_phase = '0;
        end
        // With the fixed half duty this compare reduces to ~phase MSB.
        w_next_wave = w_cur_en && (w_next_phase[ACC_W-1 -: DUTY_W] < w_cur_duty);
    end

    logic [MIX_W-1:0] w_pop;

    always_comb begin
        w_pop = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            w_pop = w_pop + MIX_W'(r_wave[c]);
        end
    end

    // An out-of-range ch_i matches no voice, so such a write is dropped.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_idx  <= '0;
            r_en   <= '0;
            r_wave <= '0;
            r_mix  <= '0;
            r_tick <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                r_phase[c] <= '0;
                r_inc[c]   <= '0;
`ifdef POLY_OSC_DUTY_EN
                r_duty[c]  <= DUTY_HALF;
`endif
            end
        end else begin
            r_idx  <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
            r_tick <= (r_idx == LAST_IDX);
            r_mix  <= w_pop;
            for (int c = 0; c < CHANNELS; c++) begin
                if (r_idx == CH_W'(c)) begin
                    r_phase[c] <= w_next_phase;
                    r_wave[c]  <= w_next_wave;
                end
                if (wr_i && (ch_i == CH_W'(c))) begin
                    r_inc[c] <= w_inc_new;
                    r_en[c]  <= enable_i;
`ifdef POLY_OSC_DUTY_EN
                    r_duty[c] <= duty_i;
`endif
                    if (retrig_i) begin
                        r_phase[c] <= '0;
                    end
                end
            end
        end
    end

    assign wave_o = r_wave;
    assign mix_o  = r_mix;
    assign tick_o = r_tick;

endmodule

// File: tb/tb_poly_osc.sv
// tb_poly_osc: directed test of poly_osc (4-voice main instance plus a 5-voice instance for select range and frame length).
// Expected values are hand-derived from the note/increment formula and the slot timing.
module tb_poly_osc;
    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       wr;
    logic [1:0] ch;
    logic [7:0] note;
    logic       en;
    logic       retrig;
    logic [3:0] wave;
    logic [2:0] mix;
    logic       tick;

    logic       wr5;
    logic [2:0] ch5;
    logic [7:0] note5;
    logic       en5;
    logic [4:0] wave5;
    logic [2:0] mix5;
    logic       tick5;

`ifdef POLY_OSC_DUTY_EN
    logic [7:0] duty_req = 8'd128;
    logic [7:0] duty5    = 8'd128;
`endif

    poly_osc dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .wr_i     (wr),
        .ch_i     (ch),
        .note_i   (note),
        .enable_i (en),
        .retrig_i (retrig),
`ifdef POLY_OSC_DUTY_EN
        .duty_i   (duty_req),
`endif
        .wave_o   (wave),
        .mix_o    (mix),
        .tick_o   (tick)
    );

    poly_osc #(.CHANNELS(5)) dut5 (
        .clk_i    (clk),
        .rst_i    (rst),
        .wr_i     (wr5),
        .ch_i     (ch5),
        .note_i   (note5),
        .enable_i (en5),
        .retrig_i (1'b0),
`ifdef POLY_OSC_DUTY_EN
        .duty_i   (duty5),
`endif
        .wave_o   (wave5),
        .mix_o    (mix5),
        .tick_o   (tick5)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_voice(input logic [1:0] c, input logic [7:0] n, input logic e, input logic r);
        ch = c; note = n; en = e; retrig = r; wr = 1'b1;
        step();
        wr = 1'b0; retrig = 1'b0;
    endtask

    task automatic sync_tick(input string tag);
        int i = 0;
        while (!tick && i < 16) begin
            step();
            i++;
        end
        check(tag, 32'(tick), 32'd1);
    endtask

    // Voice 1 is written in an idx==0 cycle, so its first service is the next edge.
    task automatic fall_srv(input logic [7:0] n, input int max_srv, output int srv);
        sync_tick("sync fall");
        wr_voice(2'd1, n, 1'b1, 1'b1);
        step();
        srv = 1;
        while (wave[1] && srv < max_srv) begin
            repeat (4) step();
            srv++;
        end
    endtask

    int         t4_first, t4_cnt, t5_first, t5_cnt;
    int         ev0 [3];
    int         ev2 [4];
    int         n0, n2, mix_bad, side_bad, srv;
    logic [3:0] prev_wave;

    initial begin
        #20_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rst = 1'b1; wr = 1'b0; ch = '0; note = '0; en = 1'b0; retrig = 1'b0;
        wr5 = 1'b0; ch5 = '0; note5 = '0; en5 = 1'b0;
        repeat (2) step();
        check("reset wave", 32'(wave), 32'd0);
        check("reset mix", 32'(mix), 32'd0);
        check("reset tick", 32'(tick), 32'd0);
        rst = 1'b0;

        t4_first = 0; t4_cnt = 0; t5_first = 0; t5_cnt = 0;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (tick) begin
                if (t4_first == 0) t4_first = k;
                t4_cnt++;
            end
            if (tick5) begin
                if (t5_first == 0) t5_first = k;
                t5_cnt++;
            end
        end
        check("tick first", t4_first, 4);
        check("tick count", t4_cnt, 3);
        check("tick5 first", t5_first, 5);
        check("tick5 count", t5_cnt, 2);

        // Voice 0 written in its own slot (old en=0 applies), voice 2 one cycle later.
        sync_tick("sync indep");
        wr_voice(2'd0, 8'd69, 1'b1, 1'b1);
        check("collision old en", 32'(wave[0]), 32'd0);
        wr_voice(2'd2, 8'd81, 1'b1, 1'b1);
        check("inc note69", 32'(dut.r_inc[0]), 32'd2952);
        check("inc note81", 32'(dut.r_inc[2]), 32'd5905);
        prev_wave = wave;
        n0 = 0; n2 = 0; mix_bad = 0; side_bad = 0;
        ev0 = '{-1, -1, -1};
        ev2 = '{-1, -1, -1, -1};
        for (int k = 2; k <= 22740; k++) begin
            step();
            if (mix !== 3'($countones(prev_wave))) mix_bad++;
            if (wave[1] || wave[3]) side_bad++;
            if (wave[0] != prev_wave[0] && n0 < 3) begin ev0[n0] = k; n0++; end
            if (wave[2] != prev_wave[2] && n2 < 4) begin ev2[n2] = k; n2++; end
            prev_wave = wave;
        end
        check("v0 rise", ev0[0], 4);
        check("v0 fall", ev0[1], 11368);
        check("v0 rerise", ev0[2], 22736);
        check("v2 rise", ev2[0], 2);
        check("v2 fall", ev2[1], 5682);
        check("v2 rerise", ev2[2], 11366);
        check("v2 refall", ev2[3], 17046);
        check("mix lag errors", mix_bad, 0);
        check("idle voices high", side_bad, 0);

        // Reset while running, with a write pending in the same cycles.
        rst = 1'b1; wr = 1'b1; ch = 2'd3; note = 8'd69; en = 1'b1;
        repeat (2) step();
        check("midrst wave", 32'(wave), 32'd0);
        check("midrst mix", 32'(mix), 32'd0);
        check("midrst tick", 32'(tick), 32'd0);
        check("midrst inc0", 32'(dut.r_inc[0]), 32'd0);
        check("midrst inc3", 32'(dut.r_inc[3]), 32'd0);
        rst = 1'b0; wr = 1'b0; en = 1'b0;
        repeat (8) step();
        check("post rst quiet", 32'(wave), 32'd0);

        // Retrigger and write collisions in voice 1's own slot (cycle S has idx 0).
        sync_tick("sync retrig");
        wr_voice(2'd1, 8'd69, 1'b1, 1'b1);
        step();
        check("v1 first svc phase", 32'(dut.r_phase[1]), 32'd2952);
        check("v1 first svc wave", 32'(wave[1]), 32'd1);
        repeat (3) step();
        wr_voice(2'd1, 8'd81, 1'b1, 1'b0);
        check("v1 old inc used", 32'(dut.r_phase[1]), 32'd5904);
        repeat (3) step();
        wr_voice(2'd1, 8'd81, 1'b1, 1'b1);
        check("v1 retrig prio", 32'(dut.r_phase[1]), 32'd0);
        repeat (4) step();
        check("v1 after retrig phase", 32'(dut.r_phase[1]), 32'd5905);
        check("v1 after retrig wave", 32'(wave[1]), 32'd1);
        wr_voice(2'd1, 8'd81, 1'b0, 1'b0);
        repeat (3) step();
        check("v1 disabled wave", 32'(wave[1]), 32'd0);
        check("v1 disabled phase", 32'(dut.r_phase[1]), 32'd5905);
        repeat (4) step();
        check("v1 phase held", 32'(dut.r_phase[1]), 32'd5905);

        // Note clamp and extremes of the shift range.
        wr_voice(2'd3, 8'd200, 1'b0, 1'b0);
        check("inc note200", 32'(dut.r_inc[3]), 32'd84180);
        wr_voice(2'd3, 8'd0, 1'b0, 1'b0);
        check("inc note0", 32'(dut.r_inc[3]), 32'd54);
        wr_voice(2'd3, 8'd127, 1'b0, 1'b0);
        check("inc note127", 32'(dut.r_inc[3]), 32'd84180);
        wr_voice(2'd3, 8'd12, 1'b0, 1'b0);
        check("inc note12", 32'(dut.r_inc[3]), 32'd109);
        wr_voice(2'd3, 8'd60, 1'b0, 1'b0);
        check("inc note60", 32'(dut.r_inc[3]), 32'd1755);
        wr_voice(2'd3, 8'd128, 1'b0, 1'b0);
        check("inc note128", 32'(dut.r_inc[3]), 32'd84180);
        fall_srv(8'd200, 150, srv);
        check("note200 fall svc", srv, 100);

        // 5-voice instance: selects 5 and 7 do not exist.
        wr5 = 1'b1; ch5 = 3'd5; note5 = 8'd127; en5 = 1'b1;
        step();
        ch5 = 3'd7;
        step();
        wr5 = 1'b0;
        repeat (10) step();
        check("oor write ignored", 32'(wave5), 32'd0);
        wr5 = 1'b1; ch5 = 3'd4;
        step();
        wr5 = 1'b0;
        repeat (6) step();
        check("last voice write", 32'(wave5), 32'd16);
        check("last voice mix", 32'(mix5), 32'd1);

`ifdef POLY_OSC_DUTY_EN
        duty_req = 8'd64;
        fall_srv(8'd69, 1500, srv);
        check("duty64 fall svc", srv, 1421);
        duty_req = 8'd0;
        fall_srv(8'd69, 10, srv);
        check("duty0 fall svc", srv, 1);
        duty_req = 8'd255;
        fall_srv(8'd127, 300, srv);
        check("duty255 fall svc", srv, 199);
        duty_req = 8'd128;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
